// File: rtl/mmio_lsu_pkg.sv
// Shared encodings for the MMIO load/store unit: access sizes, FSM states, GPIO map.
// The sub-word store path is selected with the MMIO_LSU_RMW_EN macro.
package mmio_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   localparam logic [31:0] GPIO_DATA_ADDR = 32'hFFFF_0010;
   localparam logic [31:0] GPIO_DIR_ADDR  = 32'hFFFF_0014;

   // Size code 11 is treated as an alignment failure so callers need one test only.
   function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = |off;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mmio_lsu_lane_align.sv
// Byte-lane steering for the LSU: load extract/extend and sub-word store merge.
// Purely combinational; the macro MMIO_LSU_RMW_EN does not affect this block.
module lsu_lane_align
   import mmio_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] i_word,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [1:0]        i_off,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   output logic [DATA_W-1:0] o_ld_data,
   output logic [DATA_W-1:0] o_st_word
);

   logic signed [7:0]  w_byte;
   logic signed [15:0] w_half;

   assign w_byte = i_word[{i_off, 3'b000} +: 8];
   assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

   // Sized casts of the signed lanes perform the sign extension.
   always_comb begin
      o_ld_data = i_word;
      case (i_size)
         SZ_BYTE: o_ld_data = i_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}  : DATA_W'(w_byte);
         SZ_HALF: o_ld_data = i_unsigned ? {{(DATA_W-16){1'b0}}, w_half} : DATA_W'(w_half);
         default: o_ld_data = i_word;
      endcase
   end

   always_comb begin
      o_st_word = i_word;
      case (i_size)
         SZ_BYTE: o_st_word[{i_off, 3'b000} +: 8] = i_wdata[7:0];
         SZ_HALF: begin
            if (i_off[1]) o_st_word[31:16] = i_wdata[15:0];
            else          o_st_word[15:0]  = i_wdata[15:0];
         end
         default: o_st_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/mmio_lsu.sv
// MMIO load/store unit: CPU byte/half/word requests to word-only bus cycles.
// MMIO_LSU_RMW_EN enables read-modify-write sub-word stores; otherwise they are rejected.
module mmio_lsu
   import mmio_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   output logic              write_enable,
   input  logic [DATA_W-1:0] read_data
);

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic                r_unsigned;
   logic                r_err;
   logic [1:0]          r_size;
   logic [1:0]          r_off;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_old;
   logic [ADDR_W-1:0]   r_address;
   logic [DATA_W-1:0]   r_write_data;
   logic                w_accept;
   logic                w_err;
   logic                w_word_store;
   logic [DATA_W-1:0]   w_align_word;
   logic [DATA_W-1:0]   w_ld_data;
   logic [DATA_W-1:0]   w_st_word;

   assign w_accept     = req_valid && req_ready;
   assign w_word_store = req_we && (req_size == SZ_WORD);

   always_comb begin
      w_err = is_bad_access(req_size, req_addr[1:0]);
`ifndef MMIO_LSU_RMW_EN
      if (req_we && (req_size != SZ_WORD)) w_err = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err)             w_next = ST_RESP;
               else if (w_word_store) w_next = ST_WR;
               else                   w_next = ST_RD;
            end
         end
         ST_RD:   w_next = r_we ? ST_WR : ST_RESP;
         ST_WR:   w_next = ST_RESP;
         ST_RESP: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Bus address/data registers hold their value whenever no bus cycle is running.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_address    <= '0;
         r_write_data <= '0;
      end else begin
         if (w_accept && !w_err) begin
            r_address <= {req_addr[ADDR_W-1:2], 2'b00};
            if (w_word_store) r_write_data <= req_wdata;
         end
         if ((r_state == ST_RD) && r_we) r_write_data <= w_st_word;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we       <= req_we;
         r_unsigned <= req_unsigned;
         r_err      <= w_err;
         r_size     <= req_size;
         r_off      <= req_addr[1:0];
         r_wdata    <= req_wdata;
      end
      if (r_state == ST_RD) r_old <= read_data;
   end

   // During RD the merge works on the live bus word; in RESP the load uses the captured one.
   assign w_align_word = (r_state == ST_RD) ? read_data : r_old;

   lsu_lane_align #(.DATA_W(DATA_W)) u_align (
      .i_word     (w_align_word),
      .i_wdata    (r_wdata),
      .i_off      (r_off),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_ld_data  (w_ld_data),
      .o_st_word  (w_st_word)
   );

   // Strobes are masked by rst so an aborted access never reaches the bus or the CPU.
   always_comb begin
      req_ready    = (r_state == ST_IDLE);
      resp_valid   = (r_state == ST_RESP) && !rst;
      resp_err     = resp_valid && r_err;
      resp_rdata   = (resp_valid && !r_we && !r_err) ? w_ld_data : '0;
      write_enable = (r_state == ST_WR) && !rst;
   end

   assign address    = r_address;
   assign write_data = r_write_data;

endmodule

// File: tb/tb_mmio_lsu.sv
// Self-checking bench for mmio_lsu: directed plan cases plus randomized RAM traffic
// checked against a lane-arithmetic reference model (honours MMIO_LSU_RMW_EN).
module tb_mmio_lsu;
   import mmio_lsu_pkg::*;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] read_data;

   mmio_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .address      (address),
      .write_data   (write_data),
      .write_enable (write_enable),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus slave: word RAM at low addresses plus two GPIO registers, with a backdoor preload.
   logic [31:0] ram [0:255];
   logic [31:0] gpio_data;
   logic [31:0] gpio_dir;
   logic        bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_val;

   always @(posedge clk) begin
      if (rst) begin
         gpio_data <= 32'h0;
         gpio_dir  <= 32'h0;
      end
      if (write_enable) begin
         if (address == GPIO_DATA_ADDR)     gpio_data <= write_data;
         else if (address == GPIO_DIR_ADDR) gpio_dir  <= write_data;
         else                               ram[address[9:2]] <= write_data;
      end
      if (bd_we) ram[bd_idx] <= bd_val;
   end

   always_comb begin
      if (address == GPIO_DATA_ADDR)     read_data = gpio_data;
      else if (address == GPIO_DIR_ADDR) read_data = gpio_dir;
      else                               read_data = ram[address[9:2]];
   end

   int          we_cnt = 0;
   int          rv_cnt = 0;
   int          we_consec = 0;
   int          bad_addr = 0;
   logic        prev_we = 1'b0;
   logic [31:0] last_wdata = 32'h0;

   always @(posedge clk) begin
      if (write_enable) begin
         we_cnt++;
         last_wdata = write_data;
         if (address[1:0] != 2'b00) bad_addr++;
      end
      if (write_enable && prev_we) we_consec++;
      prev_we = write_enable;
      if (resp_valid) rv_cnt++;
   end

   int n_vec = 0;
   int n_mis = 0;
   logic [31:0] exp_mem [0:255];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] val);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_idx = idx; bd_val = val;
      @(posedge clk); #1;
      bd_we = 1'b0;
      exp_mem[idx] = val;
   endtask

   // Reference: access width in bytes, lane mask by shifting, sign fix by subtracting 2^bits.
   function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic e, output logic [31:0] rd,
                                 output int lat, output int nwe);
      int nb;
      int sh;
      longint unsigned word, mask, v;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      sh  = 8 * int'(a[1:0]);
      e   = (sz == 2'b11) || ((int'(a[1:0]) % nb) != 0);
`ifndef MMIO_LSU_RMW_EN
      if (we && (sz != 2'b10)) e = 1'b1;
`endif
      rd  = 32'h0;
      lat = 1;
      nwe = 0;
      if (!e) begin
         word = longint'(exp_mem[a[9:2]]);
         mask = (64'd1 << (8 * nb)) - 64'd1;
         if (!we) begin
            v = (word >> sh) & mask;
            if (!uns && (nb < 4) && (v >= (mask + 64'd1) / 2)) rd = 32'(v - (mask + 64'd1));
            else                                                 rd = 32'(v);
            lat = 2;
         end else begin
            exp_mem[a[9:2]] = 32'((word & ~(mask << sh)) | ((longint'(wd) & mask) << sh));
            lat = (nb == 4) ? 2 : 3;
            nwe = 1;
         end
      end
   endfunction

   task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd, input int e_lat, input int e_nwe);
      int          lat;
      int          we0;
      logic        got;
      logic [31:0] o_rd;
      logic        o_err;
      @(posedge clk); #1;
      check({tag, ".ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      we0 = we_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; got = 1'b0; o_rd = 32'h0; o_err = 1'b0;
      while (!got && lat < 8) begin
         lat++;
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1; o_rd = resp_rdata; o_err = resp_err;
         end else if (lat < 8) begin
            @(posedge clk);
         end
      end
      check({tag, ".resp_seen"}, 32'(got), 32'd1);
      check({tag, ".latency"}, 32'(lat), 32'(e_lat));
      check({tag, ".err"}, 32'(o_err), 32'(e_err));
      check({tag, ".rdata"}, o_rd, e_rd);
      @(posedge clk); #1;
      check({tag, ".resp_one_cycle"}, 32'(resp_valid), 32'd0);
      check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
      check({tag, ".bus_writes"}, 32'(we_cnt - we0), 32'(e_nwe));
   endtask

   initial begin
      logic        e;
      logic [31:0] rd;
      int          lat;
      int          nwe;
      int          we0;
      int          rv0;
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] a;
      logic [31:0] wd;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_idx = 8'h0; bd_val = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.write_enable", 32'(write_enable), 32'd0);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.address", address, 32'h0);
      check("rst.write_data", write_data, 32'h0);
      check("rst.resp_rdata", resp_rdata, 32'h0);
      check("rst.resp_err", 32'(resp_err), 32'd0);

      do_req("sw_gpio", 1'b1, SZ_WORD, 1'b0, GPIO_DIR_ADDR, 32'h0000_00FF, 1'b0, 32'h0, 2, 1);
      check("sw_gpio.write_data", last_wdata, 32'h0000_00FF);
      check("sw_gpio.reg", gpio_dir, 32'h0000_00FF);
      do_req("lw_gpio", 1'b0, SZ_WORD, 1'b0, GPIO_DIR_ADDR, 32'h0, 1'b0, 32'h0000_00FF, 2, 0);

      poke(8'h40, 32'h1122_3344);
`ifdef MMIO_LSU_RMW_EN
      do_req("sb_rmw", 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_00AA, 1'b0, 32'h0, 3, 1);
      check("sb_rmw.ram", ram[8'h40], 32'h1122_AA44);
`else
      do_req("sb_rej", 1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h0000_00AA, 1'b1, 32'h0, 1, 0);
      check("sb_rej.ram", ram[8'h40], 32'h1122_3344);
`endif

      poke(8'h40, 32'h80FF_0000);
      do_req("lb_103", 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0);
      do_req("lbu_103", 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 1'b0, 32'h0000_0080, 2, 0);
      do_req("lh_102", 1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0);
      do_req("lhu_100", 1'b0, SZ_HALF, 1'b1, 32'h100, 32'h0, 1'b0, 32'h0000_0000, 2, 0);

      do_req("lw_mis", 1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1, 0);
      do_req("sh_mis", 1'b1, SZ_HALF, 1'b0, 32'h101, 32'h0000_BEEF, 1'b1, 32'h0, 1, 0);
      do_req("ill_size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0);

      poke(8'h40, 32'h1122_3344);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
      req_addr = 32'h100; req_wdata = 32'h0000_00AA;
      we0 = we_cnt; rv0 = rv_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid.bus_writes", 32'(we_cnt - we0), 32'd0);
      check("rst_mid.responses", 32'(rv_cnt - rv0), 32'd0);
      check("rst_mid.ram", ram[8'h40], 32'h1122_3344);
      check("rst_mid.req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 16; i++) poke(8'(8'h40 + i), $urandom);
      for (int i = 0; i < 60; i++) begin
         we  = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = 32'h100 + 32'($urandom_range(0, 63));
         wd  = $urandom;
         model(we, sz, uns, a, wd, e, rd, lat, nwe);
         do_req($sformatf("rnd%0d", i), we, sz, uns, a, wd, e, rd, lat, nwe);
         check($sformatf("rnd%0d.ram", i), ram[a[9:2]], exp_mem[a[9:2]]);
      end

      check("we_back_to_back", 32'(we_consec), 32'd0);
      check("we_misaligned_addr", 32'(bad_addr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mmio_lsu.md
Name: mmio_lsu

Overview:
- Load/store unit: the bus-initiator end of the CPU's memory-mapped peripheral bus (address / write_data / write_enable / read_data).
- Turns CPU byte/half/word load and store requests into word-only bus cycles that peripherals such as gpio respond to.
- The bus has no byte strobes, so sub-word stores are done as read-modify-write.
- Sits between the CPU memory stage and the peripheral/memory bus decoder.

Parameters:
- ADDR_W, 32, width of request and bus address.
- DATA_W, 32, bus data width; fixed at 32.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  LSU can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  zero-extend loads (LBU/LHU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_rdata  output  32  aligned, extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, illegal size, or unsupported access; qualified by resp_valid.
- address  output  32  bus address, always word-aligned.
- write_data  output  32  bus write data.
- write_enable  output  1  bus write strobe; the slave captures on the posedge where it is high.
- read_data  input  32  bus read data; combinational from address and valid in the same cycle.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, address=0, write_data=0, write_enable=0, state=IDLE.
- States: IDLE, RD, WR, RESP.
- Request acceptance: accepted on a posedge with req_valid & req_ready. The request is registered and the next state is chosen then.
- Next state on accept (accept edge = cycle N):
  - Error: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> RESP. resp_err=1, no bus cycle, resp_valid in cycle N+1.
  - Load -> RD: address={addr[31:2],2'b00}, write_enable=0. read_data captured at the end of RD -> RESP. resp_valid in cycle N+2.
  - Word store -> WR: write_enable=1 for exactly one cycle, write_data=req_wdata -> RESP. resp_valid in N+2.
  - Sub-word store -> RD (capture the old word) -> WR (merged word: new lanes replaced, others kept) -> RESP. resp_valid in N+3.
- Lane select uses addr[1:0] for bytes and addr[1] for halves.
- Load extension: sign-extend from bit 7 or bit 15 unless req_unsigned; word loads ignore req_unsigned.
- RESP always returns to IDLE next cycle. Back-to-back requests: req_ready is high again in the cycle after RESP.
- Bus outputs outside RD/WR: write_enable=0; address and write_data hold their last values.
- write_enable never high outside WR; never two consecutive cycles.
- Reset mid-operation: the next state is IDLE. Any pending WR is dropped (write_enable=0 in the reset cycle and after). No resp_valid for the aborted request.
- req_* are ignored when req_ready=0.

Optional Feature:
- Macro: MMIO_LSU_RMW_EN.
- Defined: sub-word stores use RD->WR read-modify-write as above.
- Undefined: sub-word stores are rejected. They go IDLE->RESP with resp_err=1 and no bus cycle. Byte/half loads are unaffected.

Decomposition:
- Package mmio_lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - GPIO_DATA_ADDR=32'hFFFF0010 and GPIO_DIR_ADDR=32'hFFFF0014 for benches and firmware.
- Sub-module lsu_lane_align (combinational):
  - load extract/extend: old word, offset, size, unsigned -> rdata;
  - store merge: old word, new data, offset, size -> merged word.

Test Plan:
- Reset: rst high 2 cycles -> req_ready=1, write_enable=0, resp_valid=0, address=0.
- Store word then load to gpio: SW 0x000000FF to 0xFFFF0014 -> one write_enable cycle with write_data=0x000000FF, resp_valid at N+2. Then LW 0xFFFF0014 -> resp_rdata=0x000000FF, resp_err=0.
- Sub-word store on a word-RAM model holding 0x11223344 at 0x100: SB 0xAA to 0x101 -> bus read, then write 0x1122AA44, resp_valid at N+3. With MMIO_LSU_RMW_EN undefined -> resp_err=1 at N+1, memory unchanged.
- Loads from RAM word 0x80FF0000 at 0x100:
  - LB 0x103 -> 0xFFFFFF80;
  - LBU 0x103 -> 0x00000080;
  - LH 0x102 -> 0xFFFF80FF;
  - LHU 0x100 -> 0x00000000.
- Misaligned: LW 0x102 and SH 0x101 -> resp_err=1 at N+1, resp_rdata=0, write_enable never asserted.
- Reset mid-store: assert rst during RD of SB to 0x100 -> no write_enable pulse, no resp_valid, RAM still 0x11223344, req_ready=1 after reset.
